reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file with a per-register pending-write scoreboard and a self-initialising reset sequence.
- Successor to the single-write/two-read architectural register file; serves superscalar/pipelined cores.
- Provides NUM_READ combinational read ports and NUM_WRITE clocked write ports.
- Issue logic uses the busy bits to detect RAW hazards.

Parameters:
- XLEN, 32, data width of each register.
- REG_ADDR_WIDTH, 5, address width; depth = 2**REG_ADDR_WIDTH.
- NUM_READ, 2, number of read ports (>=1).
- NUM_WRITE, 1, number of write ports (>=1).
- INITIAL_SP, 32'h03FFFFFC, value loaded into x2 during init.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- addr_rs  in  NUM_READ*REG_ADDR_WIDTH  read addresses; port i at slice i.
- data_rs  out  NUM_READ*XLEN  read data; port i at slice i.
- busy_rs  out  NUM_READ  scoreboard busy bit of each read address.
- write_enable  in  NUM_WRITE  per-port write strobe.
- addr_rd  in  NUM_WRITE*REG_ADDR_WIDTH  write addresses.
- data_rd  in  NUM_WRITE*XLEN  write data.
- alloc_en  in  1  mark alloc_addr as pending a write.
- alloc_addr  in  REG_ADDR_WIDTH  register being allocated.
- ready  out  1  high once init complete; writes/allocs honoured only when high.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- State machine: INIT, RUN.
  - reset=1 at a posedge -> state=INIT, init_idx=0, all busy bits=0, ready=0. Applies mid-INIT or mid-RUN; init restarts from index 0.
  - INIT: each cycle writes registers[init_idx] = (init_idx==2 ? INITIAL_SP : 0), then init_idx++.
  - INIT -> RUN on the cycle init_idx == 2**REG_ADDR_WIDTH-1 is written; init_idx wraps to 0.
  - ready goes high the following cycle: exactly 2**REG_ADDR_WIDTH cycles after the first posedge with reset low (32 with defaults).
  - INIT: write_enable and alloc_en are ignored; data_rs reads 0 and busy_rs reads 0 for all ports.
- Reads (RUN): combinational.
  - data_rs[i] = registers[addr_rs[i]].
  - Address 0 always returns 0 regardless of array content.
  - busy_rs[i] = busy[addr_rs[i]].
- Writes (RUN):
  - Port j commits on posedge when write_enable[j]=1 and addr_rd[j]!=0.
  - Writes to x0 are discarded.
  - Two or more ports targeting the same address in one cycle: the highest-indexed port wins.
- Scoreboard (RUN):
  - alloc_en=1 and alloc_addr!=0 sets busy[alloc_addr] next cycle.
  - A valid write to address a clears busy[a] next cycle.
  - Same-cycle alloc and write to the same address: alloc wins; busy stays/becomes 1 (new producer).
  - busy[0] is constant 0; alloc of x0 is ignored.
  - A write to a non-busy register is legal and leaves busy at 0.
- Latency without bypass: a value written at edge N is visible on data_rs during cycle N+1.
- No X propagation: every register holds a defined value once ready=1.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - Read ports forward same-cycle write data. If any write port j has write_enable[j]=1, addr_rd[j]==addr_rs[i]!=0 and ready=1, then data_rs[i]=data_rd[j] (highest matching j).
  - busy_rs[i] reads 0 for such a register unless alloc_en targets the same address that cycle.
- Not defined:
  - Reads return the pre-edge array value.
  - busy_rs reflects only the registered busy vector; write-to-read latency is one cycle.

Test Plan:
- Reset high 2 cycles, release -> ready=0 for 32 cycles then 1; reading x2 gives 32'h03FFFFFC, x1 and x31 give 0, all busy_rs=0.
- RUN: port0 writes x5=32'hDEADBEEF -> next cycle data_rs[0] with addr 5 = 32'hDEADBEEF. Write x0=32'h1234 -> x0 still reads 0.
- NUM_WRITE=2: both ports write x7 (32'h11, 32'h22) same cycle -> x7 reads 32'h22.
- alloc x9 -> busy_rs=1 next cycle. Write x9 -> busy_rs=0 after. Alloc and write x9 in the same cycle -> busy stays 1 and x9 holds the written data.
- Assert reset mid-INIT at cycle 10 after writing x5 pre-reset -> ready low for a full 32 cycles again, x5 reads 0, busy cleared.
- REG_FILE_BYPASS_EN defined: write x3=32'hCAFE0001 while reading x3 the same cycle -> data_rs=32'hCAFE0001 that cycle. Undefined: the same stimulus returns the old value, and the new value appears next cycle.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with a pending-write scoreboard
// and a self-initialising reset sequence.
//
// After reset the block walks every register once, loading x2 with INITIAL_SP
// and all other registers with 0. It then enters RUN and raises ready. During
// initialisation, writes and allocations are ignored and all read ports return 0.
//
// Ports:
//   clock         sole clock, all state changes on posedge
//   reset         synchronous, active-high; restarts initialisation from index 0
//   addr_rs       NUM_READ read addresses, port i at slice i
//   data_rs       NUM_READ read data words (combinational)
//   busy_rs       scoreboard busy bit of each read address
//   write_enable  per-write-port strobe
//   addr_rd       NUM_WRITE write addresses
//   data_rd       NUM_WRITE write data words
//   alloc_en      mark alloc_addr as awaiting a write
//   alloc_addr    register being allocated
//   ready         high once initialisation has finished
//
// Optional build macro REG_FILE_BYPASS_EN: read ports forward same-cycle write
// data and hide the busy bit of a register that is being written this cycle.

module reg_file_mp #(
   parameter int unsigned     XLEN           = 32,
   parameter int unsigned     REG_ADDR_WIDTH = 5,
   parameter int unsigned     NUM_READ       = 2,
   parameter int unsigned     NUM_WRITE      = 1,
   parameter logic [XLEN-1:0] INITIAL_SP     = 32'h03FFFFFC
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [NUM_READ*REG_ADDR_WIDTH-1:0] addr_rs,
   output logic [NUM_READ*XLEN-1:0]           data_rs,
   output logic [NUM_READ-1:0]                busy_rs,
   input  logic [NUM_WRITE-1:0]               write_enable,
   input  logic [NUM_WRITE*REG_ADDR_WIDTH-1:0] addr_rd,
   input  logic [NUM_WRITE*XLEN-1:0]          data_rd,
   input  logic                               alloc_en,
   input  logic [REG_ADDR_WIDTH-1:0]          alloc_addr,
   output logic                               ready
);

   localparam int unsigned DEPTH = 2 ** REG_ADDR_WIDTH;

   typedef logic [REG_ADDR_WIDTH-1:0] addr_t;
   typedef logic [XLEN-1:0]           word_t;

   typedef enum logic {StInit, StRun} state_e;

   state_e           state_q, state_d;
   addr_t            init_idx_q, init_idx_d;
   word_t            regs_q [DEPTH];
   word_t            regs_d [DEPTH];
   logic [DEPTH-1:0] busy_q, busy_d;

   // Unpacked views of the flattened write ports.
   addr_t wr_addr [NUM_WRITE];
   word_t wr_data [NUM_WRITE];
   logic  wr_valid [NUM_WRITE];

   always_comb begin
      for (int unsigned j = 0; j < NUM_WRITE; j++) begin
         wr_addr[j]  = addr_rd[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
         wr_data[j]  = data_rd[j*XLEN +: XLEN];
         wr_valid[j] = write_enable[j] && (wr_addr[j] != '0);
      end
   end

   assign ready = (state_q == StRun);

   // ---------------------------------------------------------------------------
   // Control FSM: INIT walks every index once, then RUN forever until reset.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      unique case (state_q)
         StInit: begin
            init_idx_d = init_idx_q + addr_t'(1);
            if (init_idx_q == addr_t'(DEPTH - 1)) begin
               state_d = StRun;
            end
         end
         StRun: begin
            state_d = StRun;
         end
         default: begin
            state_d    = StInit;
            init_idx_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StInit;
         init_idx_q <= '0;
         busy_q     <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
         busy_q     <= busy_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Register array. Ports are applied in ascending order so the highest-indexed
   // port targeting an address wins.
   // ---------------------------------------------------------------------------
   always_comb begin
      regs_d = regs_q;
      if (state_q == StInit) begin
         regs_d[init_idx_q] = (init_idx_q == addr_t'(2)) ? INITIAL_SP : '0;
      end else begin
         for (int unsigned j = 0; j < NUM_WRITE; j++) begin
            if (wr_valid[j]) begin
               regs_d[wr_addr[j]] = wr_data[j];
            end
         end
      end
   end

   // The array is reloaded by the init walk, so it needs no reset of its own.
   always_ff @(posedge clock) begin
      if (!reset) begin
         regs_q <= regs_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard: writes clear, the allocation is applied last so a same-cycle
   // allocation (a new producer) wins over the completing write.
   // ---------------------------------------------------------------------------
   always_comb begin
      busy_d = busy_q;
      if (state_q == StRun) begin
         for (int unsigned j = 0; j < NUM_WRITE; j++) begin
            if (wr_valid[j]) begin
               busy_d[wr_addr[j]] = 1'b0;
            end
         end
         if (alloc_en && (alloc_addr != '0)) begin
            busy_d[alloc_addr] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   // ---------------------------------------------------------------------------
   // Read ports.
   // ---------------------------------------------------------------------------
   always_comb begin
      addr_t rd_addr;
      word_t rd_val;
      logic  rd_busy;
`ifdef REG_FILE_BYPASS_EN
      logic  fwd_hit;
`endif
      data_rs = '0;
      busy_rs = '0;
      for (int unsigned i = 0; i < NUM_READ; i++) begin
         rd_addr = addr_rs[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
         rd_val  = (rd_addr == '0) ? '0 : regs_q[rd_addr];
         rd_busy = busy_q[rd_addr];
`ifdef REG_FILE_BYPASS_EN
         fwd_hit = 1'b0;
         for (int unsigned j = 0; j < NUM_WRITE; j++) begin
            if (wr_valid[j] && (wr_addr[j] == rd_addr)) begin
               rd_val  = wr_data[j];
               fwd_hit = 1'b1;
            end
         end
         // A completing write satisfies the consumer unless a new producer is
         // being allocated to the same register in this cycle.
         if (fwd_hit && !(alloc_en && (alloc_addr == rd_addr))) begin
            rd_busy = 1'b0;
         end
`endif
         if (!ready) begin
            rd_val  = '0;
            rd_busy = 1'b0;
         end
         data_rs[i*XLEN +: XLEN] = rd_val;
         busy_rs[i]              = rd_busy;
      end
   end

endmodule
